// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the program-counter sequencer: the width of the
//   op field driven by decode and the op-code values it carries.
//   Op-codes 5..7 are reserved and are treated as NEXT by the sequencer.
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        PC_OP_NEXT = 3'd0,
        PC_OP_JABS = 3'd1,
        PC_OP_JREL = 3'd2,
        PC_OP_CALL = 3'd3,
        PC_OP_RET  = 3'd4
    } pc_op_e;

endpackage

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
//   Return-address stack (LIFO) of STACK_DEPTH entries, each ADDR_W bits.
//   A push while full and a pop while empty are ignored here; the caller
//   decides how to report them. full/empty are registered alongside the
//   stack pointer, decoded from its next value.
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (empties the stack)
//   i_push   in   push i_data this cycle
//   i_pop    in   pop the top entry this cycle
//   i_data   in   value to push
//   o_top    out  current top-of-stack entry (valid when not empty)
//   o_full   out  stack holds STACK_DEPTH entries
//   o_empty  out  stack holds no entries
// ---------------------------------------------------------------------------
module pc_ras #(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_full,
    output logic              o_empty
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_full;
    logic              r_empty;

    logic [SP_W-1:0]   w_spNext;
    logic              w_doPush;
    logic              w_doPop;
    logic [IDX_W-1:0]  w_wrIdx;
    logic [IDX_W-1:0]  w_topIdx;

    assign w_doPush = i_push && !r_full;
    assign w_doPop  = i_pop && !r_empty && !w_doPush;

    // sp points at the first free slot; the top entry sits one below it.
    assign w_wrIdx  = r_sp[IDX_W-1:0];
    assign w_topIdx = IDX_W'(r_sp - SP_ONE);

    always_comb begin
        w_spNext = r_sp;
        if (w_doPush) begin
            w_spNext = r_sp + SP_ONE;
        end else if (w_doPop) begin
            w_spNext = r_sp - SP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_sp    <= w_spNext;
            r_full  <= (w_spNext == SP_MAX);
            r_empty <= (w_spNext == '0);
        end
    end

    // Entry contents need no reset: an empty stack never exposes them.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[w_wrIdx] <= i_data;
        end
    end

    assign o_top   = r_mem[w_topIdx];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/pc_seq_unit.sv
// ---------------------------------------------------------------------------
// pc_seq_unit
//   Program-counter sequencer feeding the instruction-memory address.
//   Supports sequential fetch, absolute and relative jumps, and (with the
//   PC_RAS_EN macro defined) call/return through a return-address stack with
//   sticky overflow/underflow flags. Without PC_RAS_EN, CALL acts as JABS,
//   RET acts as NEXT and the stack/error outputs are tied off.
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   pc_en        in   1 = advance this cycle, 0 = hold all state
//   op           in   NEXT/JABS/JREL/CALL/RET (5..7 act as NEXT)
//   target       in   absolute target or two's-complement offset (JREL)
//   err_clr      in   clears sticky error flags, independent of pc_en
//   addr         out  current PC (registered)
//   stack_full   out  return-address stack is full
//   stack_empty  out  return-address stack is empty
//   err_ovf      out  sticky: CALL issued while full
//   err_unf      out  sticky: RET issued while empty
// Configuration macro: PC_RAS_EN
// ---------------------------------------------------------------------------
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int INC         = 1,
    parameter int RESET_VEC   = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_en,
    input  logic [PC_OP_W-1:0] op,
    input  logic [ADDR_W-1:0]  target,
    input  logic               err_clr,
    output logic [ADDR_W-1:0]  addr,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               err_ovf,
    output logic               err_unf
);

    localparam logic [ADDR_W-1:0] INC_V   = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_VEC);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_nextAddr;
    logic [ADDR_W-1:0] w_seqAddr;
    logic [ADDR_W-1:0] w_relAddr;

`ifdef PC_RAS_EN
    logic              w_push;
    logic              w_pop;
    logic              w_callOvf;
    logic              w_retUnf;
    logic [ADDR_W-1:0] w_rasTop;
    logic              w_rasFull;
    logic              w_rasEmpty;
    logic              r_errOvf;
    logic              r_errUnf;
`endif

    // Both sums wrap modulo 2^ADDR_W; a negative JREL offset is just a large
    // unsigned addend.
    assign w_seqAddr = r_addr + INC_V;
    assign w_relAddr = r_addr + target;

    always_comb begin
        w_nextAddr = r_addr;
`ifdef PC_RAS_EN
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_callOvf  = 1'b0;
        w_retUnf   = 1'b0;
`endif
        if (pc_en) begin
            case (op)
                PC_OP_JABS: w_nextAddr = target;
                PC_OP_JREL: w_nextAddr = w_relAddr;
                PC_OP_CALL: begin
                    // The jump is taken even when the return address is lost.
                    w_nextAddr = target;
`ifdef PC_RAS_EN
                    if (w_rasFull) begin
                        w_callOvf = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
`endif
                end
                PC_OP_RET: begin
`ifdef PC_RAS_EN
                    if (w_rasEmpty) begin
                        w_nextAddr = w_seqAddr;
                        w_retUnf   = 1'b1;
                    end else begin
                        w_nextAddr = w_rasTop;
                        w_pop      = 1'b1;
                    end
`else
                    w_nextAddr = w_seqAddr;
`endif
                end
                default: w_nextAddr = w_seqAddr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= RESET_V;
        end else begin
            r_addr <= w_nextAddr;
        end
    end

    assign addr = r_addr;

`ifdef PC_RAS_EN
    pc_ras #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_seqAddr),
        .o_top   (w_rasTop),
        .o_full  (w_rasFull),
        .o_empty (w_rasEmpty)
    );

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errOvf <= 1'b0;
            r_errUnf <= 1'b0;
        end else begin
            if (w_callOvf) begin
                r_errOvf <= 1'b1;
            end else if (err_clr) begin
                r_errOvf <= 1'b0;
            end
            if (w_retUnf) begin
                r_errUnf <= 1'b1;
            end else if (err_clr) begin
                r_errUnf <= 1'b0;
            end
        end
    end

    assign stack_full  = w_rasFull;
    assign stack_empty = w_rasEmpty;
    assign err_ovf     = r_errOvf;
    assign err_unf     = r_errUnf;
`else
    logic w_unused;

    // err_clr and STACK_DEPTH have no function without the stack.
    assign w_unused    = &{1'b0, err_clr, (STACK_DEPTH >= 2)};

    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign err_ovf     = 1'b0;
    assign err_unf     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_seq_unit
//   Self-checking bench for pc_seq_unit (ADDR_W=16, INC=1, RESET_VEC=0,
//   STACK_DEPTH=4). A queue-based reference model tracks the PC, the
//   return-address stack and the sticky flags; a compare process checks
//   every DUT output against it on each falling clock edge, and directed
//   steps pin hand-computed literal values. Honours PC_RAS_EN.
// ---------------------------------------------------------------------------
module tb_pc_seq_unit;

    localparam int ADDR_W      = 16;
    localparam int INC         = 1;
    localparam int RESET_VEC   = 0;
    localparam int STACK_DEPTH = 4;

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JABS = 3'd1;
    localparam logic [2:0] OP_JREL = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pc_en;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic              err_clr;
    logic [ADDR_W-1:0] addr;
    logic              stack_full;
    logic              stack_empty;
    logic              err_ovf;
    logic              err_unf;

    int nCompared   = 0;
    int nMismatched = 0;

    pc_seq_unit #(
        .ADDR_W      (ADDR_W),
        .INC         (INC),
        .RESET_VEC   (RESET_VEC),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_en       (pc_en),
        .op          (op),
        .target      (target),
        .err_clr     (err_clr),
        .addr        (addr),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] mAddr = 16'(RESET_VEC);
    logic [15:0] mStack[$];
    bit          mOvf = 1'b0;
    bit          mUnf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit          newOvf;
        bit          newUnf;
        logic [15:0] retAddr;
        if (!rst_n) begin
            mAddr = 16'(RESET_VEC);
            mStack.delete();
            mOvf  = 1'b0;
            mUnf  = 1'b0;
        end else begin
            newOvf  = 1'b0;
            newUnf  = 1'b0;
            retAddr = mAddr + 16'(INC);
            if (pc_en) begin
                case (op)
                    OP_JABS: mAddr = target;
                    OP_JREL: mAddr = mAddr + target;
                    OP_CALL: begin
`ifdef PC_RAS_EN
                        if (mStack.size() == STACK_DEPTH) newOvf = 1'b1;
                        else mStack.push_back(retAddr);
`endif
                        mAddr = target;
                    end
                    OP_RET: begin
`ifdef PC_RAS_EN
                        if (mStack.size() == 0) begin
                            mAddr  = retAddr;
                            newUnf = 1'b1;
                        end else begin
                            mAddr = mStack.pop_back();
                        end
`else
                        mAddr = retAddr;
`endif
                    end
                    default: mAddr = retAddr;
                endcase
            end
`ifdef PC_RAS_EN
            if (newOvf) mOvf = 1'b1;
            else if (err_clr) mOvf = 1'b0;
            if (newUnf) mUnf = 1'b1;
            else if (err_clr) mUnf = 1'b0;
`endif
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%h, expected 0x%h", name, $time, actual, expected);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput("model.addr", addr, mAddr);
        checkOutput("model.stack_full", 16'(stack_full), 16'(mStack.size() == STACK_DEPTH));
        checkOutput("model.stack_empty", 16'(stack_empty), 16'(mStack.size() == 0));
        checkOutput("model.err_ovf", 16'(err_ovf), 16'(mOvf));
        checkOutput("model.err_unf", 16'(err_unf), 16'(mUnf));
    end

    // Called at a falling edge; drives inputs and returns at the next
    // falling edge, after the intervening rising edge has acted on them.
    task automatic applyStimulus(input logic en, input logic [2:0] o,
                                 input logic [15:0] tgt, input logic clr);
        pc_en   = en;
        op      = o;
        target  = tgt;
        err_clr = clr;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        pc_en   = 1'b0;
        op      = OP_NEXT;
        target  = '0;
        err_clr = 1'b0;

        // Test 1: reset, hold, sequential fetch
        repeat (2) @(negedge clk);
        checkOutput("t1.reset_addr", addr, 16'h0000);
        checkOutput("t1.reset_empty", 16'(stack_empty), 16'h0001);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, OP_NEXT, 16'h1234, 1'b0);
            checkOutput("t1.hold_addr", addr, 16'h0000);
        end
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, OP_NEXT, 16'h0000, 1'b0);
            checkOutput("t1.next_addr", addr, 16'(i));
        end

        // Test 2: jumps and wrap-around
        applyStimulus(1'b1, OP_JABS, 16'h0010, 1'b0);
        checkOutput("t2.setup", addr, 16'h0010);
        applyStimulus(1'b1, OP_JABS, 16'hAAAA, 1'b0);
        checkOutput("t2.jabs", addr, 16'hAAAA);
        applyStimulus(1'b1, OP_JREL, 16'hFFFE, 1'b0);
        checkOutput("t2.jrel_neg", addr, 16'hAAA8);
        applyStimulus(1'b1, OP_JABS, 16'h0002, 1'b0);
        applyStimulus(1'b1, OP_JREL, 16'hFFFC, 1'b0);
        checkOutput("t2.jrel_wrap", addr, 16'hFFFE);
        applyStimulus(1'b1, 3'd5, 16'h5555, 1'b0);
        checkOutput("t2.reserved5", addr, 16'hFFFF);
        applyStimulus(1'b1, OP_NEXT, 16'h0000, 1'b0);
        checkOutput("t2.next_wrap", addr, 16'h0000);
        applyStimulus(1'b1, 3'd7, 16'h5555, 1'b0);
        checkOutput("t2.reserved7", addr, 16'h0001);

        // Test 3: single call/return
        applyStimulus(1'b1, OP_JABS, 16'h0100, 1'b0);
        applyStimulus(1'b1, OP_CALL, 16'h2000, 1'b0);
        checkOutput("t3.call_addr", addr, 16'h2000);
`ifdef PC_RAS_EN
        checkOutput("t3.call_empty", 16'(stack_empty), 16'h0000);
`else
        checkOutput("t3.call_empty", 16'(stack_empty), 16'h0001);
`endif
        applyStimulus(1'b1, OP_RET, 16'h0000, 1'b0);
`ifdef PC_RAS_EN
        checkOutput("t3.ret_addr", addr, 16'h0101);
`else
        checkOutput("t3.ret_addr", addr, 16'h2001);
`endif
        checkOutput("t3.ret_empty", 16'(stack_empty), 16'h0001);

        // Test 4: fill, overflow, unwind
        applyStimulus(1'b1, OP_JABS, 16'h0300, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, OP_CALL, 16'h1000 + 16'(i * 16'h0100), 1'b0);
        end
`ifdef PC_RAS_EN
        checkOutput("t4.full_after4", 16'(stack_full), 16'h0001);
`else
        checkOutput("t4.full_after4", 16'(stack_full), 16'h0000);
`endif
        checkOutput("t4.ovf_after4", 16'(err_ovf), 16'h0000);
        applyStimulus(1'b1, OP_CALL, 16'h1400, 1'b0);
        checkOutput("t4.call5_addr", addr, 16'h1400);
`ifdef PC_RAS_EN
        checkOutput("t4.ovf_after5", 16'(err_ovf), 16'h0001);
`else
        checkOutput("t4.ovf_after5", 16'(err_ovf), 16'h0000);
`endif
        // err_clr while stalled must still clear, and the stall holds the PC.
        applyStimulus(1'b0, OP_CALL, 16'h7777, 1'b1);
        checkOutput("t4.stall_addr", addr, 16'h1400);
        checkOutput("t4.ovf_cleared", 16'(err_ovf), 16'h0000);
        begin
            logic [15:0] expRet[4];
`ifdef PC_RAS_EN
            expRet = '{16'h1201, 16'h1101, 16'h1001, 16'h0301};
`else
            expRet = '{16'h1401, 16'h1402, 16'h1403, 16'h1404};
`endif
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1'b1, OP_RET, 16'h0000, 1'b0);
                checkOutput("t4.ret_addr", addr, expRet[i]);
            end
        end
        checkOutput("t4.unwound_empty", 16'(stack_empty), 16'h0001);

        // Test 5: underflow and clear priority
        applyStimulus(1'b1, OP_JABS, 16'h0040, 1'b0);
        applyStimulus(1'b1, OP_RET, 16'h0000, 1'b0);
        checkOutput("t5.unf_addr", addr, 16'h0041);
`ifdef PC_RAS_EN
        checkOutput("t5.unf_set", 16'(err_unf), 16'h0001);
`else
        checkOutput("t5.unf_set", 16'(err_unf), 16'h0000);
`endif
        applyStimulus(1'b1, OP_RET, 16'h0000, 1'b1);
        checkOutput("t5.unf_addr2", addr, 16'h0042);
`ifdef PC_RAS_EN
        checkOutput("t5.set_wins", 16'(err_unf), 16'h0001);
`else
        checkOutput("t5.set_wins", 16'(err_unf), 16'h0000);
`endif
        applyStimulus(1'b0, OP_NEXT, 16'h0000, 1'b1);
        checkOutput("t5.unf_cleared", 16'(err_unf), 16'h0000);
        checkOutput("t5.hold_addr", addr, 16'h0042);

        // Test 6: asynchronous reset between edges with a live stack entry
        applyStimulus(1'b1, OP_JABS, 16'h0500, 1'b0);
        applyStimulus(1'b1, OP_CALL, 16'h0600, 1'b0);
        checkOutput("t6.pre_addr", addr, 16'h0600);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6.async_addr", addr, 16'h0000);
        checkOutput("t6.async_empty", 16'(stack_empty), 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, OP_NEXT, 16'h0000, 1'b0);
        checkOutput("t6.post_next", addr, 16'h0001);
        applyStimulus(1'b1, OP_RET, 16'h0000, 1'b0);
        checkOutput("t6.post_ret", addr, 16'h0002);
`ifdef PC_RAS_EN
        checkOutput("t6.stack_discarded", 16'(err_unf), 16'h0001);
`else
        checkOutput("t6.stack_discarded", 16'(err_unf), 16'h0000);
`endif
        applyStimulus(1'b0, OP_NEXT, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
